// File: rtl/move_ctrl_seq_pkg.sv
// Shared definitions for the move-from-special-register control sequencer.
package move_ctrl_seq_pkg;

    localparam int unsigned IR_W    = 32;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_MSB  = 26;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned WAIT_W  = 8;

    localparam logic [OPC_W-1:0] OP_MOVE_BASE = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFHI      = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFLO      = 5'b11001;

    typedef enum logic [STEP_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_T0    = 3'd1,
        ST_T1    = 3'd2,
        ST_TW    = 3'd3,
        ST_T2    = 3'd4,
        ST_T3    = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    function automatic logic [OPC_W-1:0] get_opcode(input logic [IR_W-1:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/move_ctrl_seq_src_decode.sv
// Opcode decode for move-from instructions: legal flag and one-hot source enable.
module move_src_decode
    import move_ctrl_seq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2
) (
    input  logic [OPC_W-1:0]   opcode,
    output logic               legal_c,
    output logic [NUM_SRC-1:0] src_c
);

    logic [OPC_W-1:0] diff;

    always_comb begin
        diff    = opcode - OP_MOVE_BASE;
        legal_c = (opcode >= OP_MOVE_BASE) && (diff < OPC_W'(NUM_SRC));
        src_c   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (legal_c && (diff == OPC_W'(i))) begin
                src_c[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_ctrl_seq.sv
// Fetch/execute control sequencer for move-from-special-register instructions.
// Optional memory-wait timeout enabled by defining MOVE_SEQ_TIMEOUT_EN.
module move_ctrl_seq
    import move_ctrl_seq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               run,
    input  logic [IR_W-1:0]    ir,
    input  logic               mem_ready,
    output logic               PCout,
    output logic               IncPC,
    output logic               MARin,
    output logic               ZLowIn,
    output logic               Zlowout,
    output logic               PCin,
    output logic               Read,
    output logic               MDRin,
    output logic               MDRout,
    output logic               IRin,
    output logic               Gra,
    output logic               Rin,
    output logic [NUM_SRC-1:0] src_out,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [STEP_W-1:0]  step
);

    if (NUM_SRC < 1 || NUM_SRC > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("move_ctrl_seq: parameter out of range");
    end

    state_t             state;
    state_t             state_n;
    logic               legal_q;
    logic               dec_legal;
    logic [NUM_SRC-1:0] dec_src;
    logic               unused_ir;

    assign unused_ir = ^ir[RA_MSB:0];
    assign step      = state;

    move_src_decode #(.NUM_SRC(NUM_SRC)) u_decode (
        .opcode  (get_opcode(ir)),
        .legal_c (dec_legal),
        .src_c   (dec_src)
    );

`ifdef MOVE_SEQ_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_n;
`endif

    // Next-state; the wait counter holds the number of TW cycles spent so far.
    always_comb begin
        state_n = state;
`ifdef MOVE_SEQ_TIMEOUT_EN
        wait_n  = '0;
`endif
        unique case (state)
            ST_IDLE:  if (run) state_n = ST_T0;
            ST_T0:    state_n = ST_T1;
            ST_T1: begin
                if (mem_ready) begin
                    state_n = ST_T2;
                end else begin
                    state_n = ST_TW;
`ifdef MOVE_SEQ_TIMEOUT_EN
                    wait_n  = WAIT_W'(1);
`endif
                end
            end
            ST_TW: begin
                if (mem_ready) begin
                    state_n = ST_T2;
                end
`ifdef MOVE_SEQ_TIMEOUT_EN
                else if (wait_cnt >= WAIT_W'(TIMEOUT)) begin
                    state_n = ST_FAULT;
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
`endif
            end
            ST_T2:    state_n = ST_T3;
            ST_T3: begin
                if (!legal_q)  state_n = ST_FAULT;
                else if (run)  state_n = ST_T0;
                else           state_n = ST_IDLE;
            end
            ST_FAULT: state_n = ST_FAULT;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Moore outputs are decoded from the state being entered so they align with step.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state   <= ST_IDLE;
            legal_q <= 1'b0;
            PCout   <= 1'b0;
            IncPC   <= 1'b0;
            MARin   <= 1'b0;
            ZLowIn  <= 1'b0;
            Zlowout <= 1'b0;
            PCin    <= 1'b0;
            Read    <= 1'b0;
            MDRin   <= 1'b0;
            MDRout  <= 1'b0;
            IRin    <= 1'b0;
            Gra     <= 1'b0;
            Rin     <= 1'b0;
            src_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fault   <= 1'b0;
`ifdef MOVE_SEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            state   <= state_n;
            if (state_n == ST_T3) begin
                legal_q <= dec_legal;
            end
            PCout   <= (state_n == ST_T0);
            IncPC   <= (state_n == ST_T0);
            MARin   <= (state_n == ST_T0);
            ZLowIn  <= (state_n == ST_T0);
            Zlowout <= (state_n == ST_T1);
            PCin    <= (state_n == ST_T1);
            Read    <= (state_n == ST_T1) || (state_n == ST_TW);
            MDRin   <= (state_n == ST_T1) || (state_n == ST_TW);
            MDRout  <= (state_n == ST_T2);
            IRin    <= (state_n == ST_T2);
            Gra     <= (state_n == ST_T3) && dec_legal;
            Rin     <= (state_n == ST_T3) && dec_legal;
            done    <= (state_n == ST_T3) && dec_legal;
            src_out <= (state_n == ST_T3) ? dec_src : '0;
            busy    <= (state_n == ST_T0) || (state_n == ST_T1) || (state_n == ST_TW) ||
                       (state_n == ST_T2) || (state_n == ST_T3);
            fault   <= (state_n == ST_FAULT);
`ifdef MOVE_SEQ_TIMEOUT_EN
            wait_cnt <= wait_n;
`endif
        end
    end

endmodule

// File: tb/tb_move_ctrl_seq.sv
// Directed self-checking bench for move_ctrl_seq (timeout case under MOVE_SEQ_TIMEOUT_EN).
module tb_move_ctrl_seq;

    logic        clock;
    logic        clear;
    logic        run;
    logic [31:0] ir;
    logic        mem_ready;
    logic PCout, IncPC, MARin, ZLowIn, Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rin;
    logic [1:0]  src_out;
    logic        busy, done, fault;
    logic [2:0]  step;

    int errors = 0;
    int checks = 0;

    // Strobe vector order: PCout IncPC MARin ZLowIn Zlowout PCin Read MDRin MDRout IRin Gra Rin
    localparam logic [11:0] S_NONE = 12'b0000_0000_0000;
    localparam logic [11:0] S_T0   = 12'b1111_0000_0000;
    localparam logic [11:0] S_T1   = 12'b0000_1111_0000;
    localparam logic [11:0] S_TW   = 12'b0000_0011_0000;
    localparam logic [11:0] S_T2   = 12'b0000_0000_1100;
    localparam logic [11:0] S_T3   = 12'b0000_0000_0011;
    // Status order: busy done fault
    localparam logic [2:0] ST_OFF  = 3'b000;
    localparam logic [2:0] ST_BUSY = 3'b100;
    localparam logic [2:0] ST_DONE = 3'b110;
    localparam logic [2:0] ST_FLT  = 3'b001;

    move_ctrl_seq #(.NUM_SRC(2), .TIMEOUT(4)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .ZLowIn(ZLowIn),
        .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rin(Rin),
        .src_out(src_out), .busy(busy), .done(done), .fault(fault), .step(step)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic [2:0] e_step, input logic [11:0] e_strb,
                             input logic [1:0] e_src, input logic [2:0] e_stat);
        chk({tag, ".step"}, 32'(step), 32'(e_step));
        chk({tag, ".strobes"}, 32'({PCout, IncPC, MARin, ZLowIn, Zlowout, PCin,
                                    Read, MDRin, MDRout, IRin, Gra, Rin}), 32'(e_strb));
        chk({tag, ".src"}, 32'(src_out), 32'(e_src));
        chk({tag, ".status"}, 32'({busy, done, fault}), 32'(e_stat));
        chk({tag, ".onehot"}, 32'($onehot0(src_out)), 32'd1);
    endtask

    initial begin
        clear = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'h0;
        tick(); tick();
        chk_cycle("reset", 3'd0, S_NONE, 2'b00, ST_OFF);
        clear = 1'b1;
        tick();
        chk_cycle("idle", 3'd0, S_NONE, 2'b00, ST_OFF);

        // MFLO, run dropped after T0: must still complete, then idle
        ir = 32'hC980_0000; mem_ready = 1'b1; run = 1'b1;
        tick(); chk_cycle("mflo.t0", 3'd1, S_T0, 2'b00, ST_BUSY);
        run = 1'b0;
        tick(); chk_cycle("mflo.t1", 3'd2, S_T1, 2'b00, ST_BUSY);
        tick(); chk_cycle("mflo.t2", 3'd4, S_T2, 2'b00, ST_BUSY);
        tick(); chk_cycle("mflo.t3", 3'd5, S_T3, 2'b10, ST_DONE);
        tick(); chk_cycle("mflo.idle", 3'd0, S_NONE, 2'b00, ST_OFF);

        // MFHI back-to-back with run held
        ir = 32'hC180_0000; run = 1'b1;
        tick(); chk_cycle("mfhi.t0", 3'd1, S_T0, 2'b00, ST_BUSY);
        tick(); tick();
        tick(); chk_cycle("mfhi.t3a", 3'd5, S_T3, 2'b01, ST_DONE);
        tick(); chk_cycle("mfhi.b2b", 3'd1, S_T0, 2'b00, ST_BUSY);
        tick(); tick();
        tick(); chk_cycle("mfhi.t3b", 3'd5, S_T3, 2'b01, ST_DONE);
        run = 1'b0;
        tick(); chk_cycle("mfhi.idle", 3'd0, S_NONE, 2'b00, ST_OFF);

        // Three memory wait cycles
        ir = 32'hC980_0000; run = 1'b1; mem_ready = 1'b0;
        tick(); run = 1'b0;
        tick(); chk_cycle("wait.t1", 3'd2, S_T1, 2'b00, ST_BUSY);
        tick(); chk_cycle("wait.tw1", 3'd3, S_TW, 2'b00, ST_BUSY);
        tick(); chk_cycle("wait.tw2", 3'd3, S_TW, 2'b00, ST_BUSY);
        tick(); chk_cycle("wait.tw3", 3'd3, S_TW, 2'b00, ST_BUSY);
        mem_ready = 1'b1;
        tick(); chk_cycle("wait.t2", 3'd4, S_T2, 2'b00, ST_BUSY);
        tick(); chk_cycle("wait.t3", 3'd5, S_T3, 2'b10, ST_DONE);
        tick(); chk_cycle("wait.idle", 3'd0, S_NONE, 2'b00, ST_OFF);

        // Illegal opcode 00001 -> FAULT, sticky until clear
        ir = 32'h0800_0000; run = 1'b1;
        tick(); tick(); tick();
        tick(); chk_cycle("ill.t3", 3'd5, S_NONE, 2'b00, ST_BUSY);
        tick(); chk_cycle("ill.fault", 3'd6, S_NONE, 2'b00, ST_FLT);
        tick(); chk_cycle("ill.sticky", 3'd6, S_NONE, 2'b00, ST_FLT);
        clear = 1'b0;
        tick(); chk_cycle("ill.clear", 3'd0, S_NONE, 2'b00, ST_OFF);
        clear = 1'b1; run = 1'b0;

        // Clear during TW, then restart
        ir = 32'hC980_0000; run = 1'b1; mem_ready = 1'b0;
        tick(); tick();
        tick(); chk_cycle("clr.tw", 3'd3, S_TW, 2'b00, ST_BUSY);
        clear = 1'b0;
        tick(); chk_cycle("clr.idle", 3'd0, S_NONE, 2'b00, ST_OFF);
        clear = 1'b1;
        tick(); chk_cycle("clr.restart", 3'd1, S_T0, 2'b00, ST_BUSY);
        run = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        tick(); chk_cycle("clr.t3", 3'd5, S_T3, 2'b10, ST_DONE);
        tick(); chk_cycle("clr.end", 3'd0, S_NONE, 2'b00, ST_OFF);

`ifdef MOVE_SEQ_TIMEOUT_EN
        // TIMEOUT=4: four TW cycles then FAULT
        run = 1'b1; mem_ready = 1'b0;
        tick(); run = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick(); chk_cycle("tmo.tw", 3'd3, S_TW, 2'b00, ST_BUSY);
        end
        tick(); chk_cycle("tmo.fault", 3'd6, S_NONE, 2'b00, ST_FLT);
        tick(); chk_cycle("tmo.sticky", 3'd6, S_NONE, 2'b00, ST_FLT);
        clear = 1'b0;
        tick(); chk_cycle("tmo.clear", 3'd0, S_NONE, 2'b00, ST_OFF);
        clear = 1'b1;
`else
        // Without the timeout, TW waits well beyond TIMEOUT
        run = 1'b1; mem_ready = 1'b0;
        tick(); run = 1'b0;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick(); chk_cycle("nto.tw", 3'd3, S_TW, 2'b00, ST_BUSY);
        end
        mem_ready = 1'b1;
        tick(); chk_cycle("nto.t2", 3'd4, S_T2, 2'b00, ST_BUSY);
        tick(); chk_cycle("nto.t3", 3'd5, S_T3, 2'b10, ST_DONE);
        tick(); chk_cycle("nto.idle", 3'd0, S_NONE, 2'b00, ST_OFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
